// File: rtl/alu_result_checker.sv
// alu_result_checker: checks the response side of a 2-bit-select, 5-bit-operand
// ALU. It accepts TXN_COUNT (sel, a, b, res) beats per run, recomputes each
// expected result in a two-stage pipeline, counts compares and mismatches,
// captures the first mismatch and ends each run with a done/pass verdict.
// Optional feature macro: ALU_CHK_STOP_ON_ERR_EN. When it is defined, the
// first mismatch ends the run at once. When it is undefined, every run
// compares all TXN_COUNT beats.
module alu_result_checker #(
  parameter int TXN_COUNT = 4,
  parameter int ERR_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       sel,
  input  logic [4:0]       a,
  input  logic [4:0]       b,
  input  logic [5:0]       res,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [7:0]       chk_cnt,
  output logic             first_err_valid,
  output logic [1:0]       first_err_sel,
  output logic [5:0]       first_err_exp,
  output logic [5:0]       first_err_got
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  localparam logic [7:0]       TXN_LIMIT = 8'(TXN_COUNT);
  localparam logic [ERR_W-1:0] ERR_MAX   = {ERR_W{1'b1}};

  state_t           state_reg, state_next;
  logic [7:0]       acc_cnt_reg;

  logic             s1_valid_reg;
  logic [1:0]       s1_sel_reg;
  logic [4:0]       s1_a_reg, s1_b_reg;
  logic [5:0]       s1_res_reg;

  logic             s2_valid_reg;
  logic             s2_mis_reg;
  logic [1:0]       s2_sel_reg;
  logic [5:0]       s2_exp_reg, s2_got_reg;

  logic [ERR_W-1:0] err_cnt_reg;
  logic [7:0]       chk_cnt_reg;
  logic             fe_valid_reg;
  logic [1:0]       fe_sel_reg;
  logic [5:0]       fe_exp_reg, fe_got_reg;

  logic             accept;
  logic             mis_hit;
  logic             stop_hit;
  logic             flush;
  logic [4:0]       and_bits, or_bits;
  logic [5:0]       exp_calc;

  // A beat is taken only while the run still needs beats; start always drops it.
  assign in_ready = (state_reg == RUN) && (acc_cnt_reg < TXN_LIMIT);
  assign accept   = in_valid && in_ready && !start;
  assign mis_hit  = s2_valid_reg && s2_mis_reg;

`ifdef ALU_CHK_STOP_ON_ERR_EN
  // Any mismatch reaching the counters ends the run, and it is always the first one.
  assign stop_hit = mis_hit;
`else
  assign stop_hit = 1'b0;
`endif

  // Beats still in flight are discarded on restart and on an early stop.
  assign flush = start || stop_hit;

  // Bitwise operations for the AND/OR opcodes.
  for (genvar gi = 0; gi < 5; gi++) begin : g_bitwise
    assign and_bits[gi] = s1_a_reg[gi] & s1_b_reg[gi];
    assign or_bits[gi]  = s1_a_reg[gi] | s1_b_reg[gi];
  end

  // Expected 6-bit result. The sum keeps its carry in bit 5. The difference wraps mod 64.
  always_comb begin
    exp_calc = '0;
    case (s1_sel_reg)
      2'd0:    exp_calc = {1'b0, s1_a_reg} + {1'b0, s1_b_reg};
      2'd1:    exp_calc = {1'b0, s1_a_reg} - {1'b0, s1_b_reg};
      2'd2:    exp_calc = {1'b0, and_bits};
      default: exp_calc = {1'b0, or_bits};
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic. start takes priority everywhere, then an early stop, then draining.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = RUN;
      RUN: begin
        if (start)                         state_next = RUN;
        else if (stop_hit)                 state_next = DONE;
        else if (acc_cnt_reg == TXN_LIMIT) state_next = DRAIN;
      end
      DRAIN: begin
        if (start)                              state_next = RUN;
        else if (stop_hit)                      state_next = DONE;
        else if (!s1_valid_reg && !s2_valid_reg) state_next = DONE;
      end
      DONE: if (start) state_next = RUN;
      default: state_next = IDLE;
    endcase
  end

  // Stage 1 registers the accepted beat and counts how many beats were taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_reg  <= '0;
      s1_valid_reg <= 1'b0;
      s1_sel_reg   <= '0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
      s1_res_reg   <= '0;
    end else begin
      s1_valid_reg <= accept && !flush;
      if (start)       acc_cnt_reg <= '0;
      else if (accept) acc_cnt_reg <= acc_cnt_reg + 8'd1;
      if (accept) begin
        s1_sel_reg <= sel;
        s1_a_reg   <= a;
        s1_b_reg   <= b;
        s1_res_reg <= res;
      end
    end
  end

  // Stage 2 registers the comparison of the stage-1 beat against its expected value.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_mis_reg   <= 1'b0;
      s2_sel_reg   <= '0;
      s2_exp_reg   <= '0;
      s2_got_reg   <= '0;
    end else begin
      s2_valid_reg <= s1_valid_reg && !flush;
      s2_mis_reg   <= (exp_calc != s1_res_reg);
      s2_sel_reg   <= s1_sel_reg;
      s2_exp_reg   <= exp_calc;
      s2_got_reg   <= s1_res_reg;
    end
  end

  // Counters and the first-mismatch capture. start clears them. Each stage-2 result updates them.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      chk_cnt_reg  <= '0;
      err_cnt_reg  <= '0;
      fe_valid_reg <= 1'b0;
      fe_sel_reg   <= '0;
      fe_exp_reg   <= '0;
      fe_got_reg   <= '0;
    end else if (s2_valid_reg) begin
      chk_cnt_reg <= chk_cnt_reg + 8'd1;
      if (s2_mis_reg && err_cnt_reg != ERR_MAX) err_cnt_reg <= err_cnt_reg + 1'b1;
      if (mis_hit && !fe_valid_reg) begin
        fe_valid_reg <= 1'b1;
        fe_sel_reg   <= s2_sel_reg;
        fe_exp_reg   <= s2_exp_reg;
        fe_got_reg   <= s2_got_reg;
      end
    end
  end

  assign busy            = (state_reg == RUN) || (state_reg == DRAIN);
  assign done            = (state_reg == DONE);
  assign pass            = done && (err_cnt_reg == '0);
  assign err_cnt         = err_cnt_reg;
  assign chk_cnt         = chk_cnt_reg;
  assign first_err_valid = fe_valid_reg;
  assign first_err_sel   = fe_sel_reg;
  assign first_err_exp   = fe_exp_reg;
  assign first_err_got   = fe_got_reg;

endmodule

// File: tb/tb_alu_result_checker.sv
// Testbench for alu_result_checker. It drives runs of four beats, some fixed
// and some random, and checks each verdict against a reference model of the
// ALU that uses plain arithmetic. It follows ALU_CHK_STOP_ON_ERR_EN when that
// macro is defined.
module tb_alu_result_checker;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [1:0] sel = '0;
  logic [4:0] a = '0;
  logic [4:0] b = '0;
  logic [5:0] res = '0;
  logic       busy, done, pass;
  logic [7:0] err_cnt, chk_cnt;
  logic       first_err_valid;
  logic [1:0] first_err_sel;
  logic [5:0] first_err_exp, first_err_got;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] t_sel[N];
  logic [4:0] t_a[N];
  logic [4:0] t_b[N];
  logic [5:0] t_res[N];

  int m_chk, m_err, m_fv, m_fsel, m_fexp, m_fgot, m_pass;

  always #5 clk = ~clk;

  alu_result_checker #(.TXN_COUNT(N), .ERR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .sel(sel), .a(a), .b(b), .res(res), .busy(busy), .done(done), .pass(pass),
    .err_cnt(err_cnt), .chk_cnt(chk_cnt), .first_err_valid(first_err_valid),
    .first_err_sel(first_err_sel), .first_err_exp(first_err_exp), .first_err_got(first_err_got)
  );

  function automatic int ref_alu(int s, int x, int y);
    case (s)
      0:       return x + y;
      1:       return (x - y + 64) % 64;
      2:       return x & y;
      default: return x | y;
    endcase
  endfunction

  task automatic set_beat(int i, int s, int x, int y, int r);
    t_sel[i] = 2'(s); t_a[i] = 5'(x); t_b[i] = 5'(y); t_res[i] = 6'(r);
  endtask

  // Expected verdict for the beats in the table.
  task automatic compute_model();
    m_chk = 0; m_err = 0; m_fv = 0; m_fsel = 0; m_fexp = 0; m_fgot = 0;
    for (int i = 0; i < N; i++) begin
      int e;
      e = ref_alu(int'(t_sel[i]), int'(t_a[i]), int'(t_b[i]));
      m_chk++;
      if (e != int'(t_res[i])) begin
        m_err++;
        if (m_fv == 0) begin
          m_fv = 1; m_fsel = int'(t_sel[i]); m_fexp = e; m_fgot = int'(t_res[i]);
        end
`ifdef ALU_CHK_STOP_ON_ERR_EN
        break;
`endif
      end
    end
    m_pass = (m_err == 0) ? 1 : 0;
  endtask

  task automatic start_run();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Sends table beats first..last-1 with random idle gaps of up to max_gap cycles.
  task automatic send_beats(int first, int last, int max_gap);
    for (int i = first; i < last; i++) begin
      bit ok;
      int g;
      ok = 0;
      g  = $urandom_range(max_gap, 0);
      repeat (g) @(negedge clk);
      if (done) break;
      in_valid = 1'b1; sel = t_sel[i]; a = t_a[i]; b = t_b[i]; res = t_res[i];
      for (int c = 0; c < 20; c++) begin
        logic rdy;
        if (done) break;
        rdy = in_ready;
        @(posedge clk);
        @(negedge clk);
        if (rdy) begin ok = 1; break; end
      end
      in_valid = 1'b0;
      if (ok) $display("txn %0d: sel=%0d a=%0d b=%0d res=%0d", i, t_sel[i], t_a[i], t_b[i], t_res[i]);
      else if (!done) begin
        n_checks++; n_fail++;
        $display("FAIL accept_timeout beat %0d: in_ready never seen, required acceptance", i);
      end
    end
  endtask

  task automatic finish_run();
    bit seen;
    seen = 0;
    in_valid = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (done) begin seen = 1; break; end
      @(negedge clk);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: done=%0b, required 1 within 40 cycles", done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pass, in_ready, first_err_valid} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: busy/done/pass/in_ready/fev=%b, required 00000",
                         {busy, done, pass, in_ready, first_err_valid});
    end
    n_checks++;
    if ({err_cnt, chk_cnt, first_err_sel, first_err_exp, first_err_got} !== 30'b0) begin
      n_fail++; $display("FAIL reset_values: err=%0d chk=%0d fe=%0d/%0d/%0d, required all 0",
                         err_cnt, chk_cnt, first_err_sel, first_err_exp, first_err_got);
    end
  endtask

  task automatic test_basic();
    set_beat(0, 0, 10, 7, 17); set_beat(1, 1, 10, 7, 3);
    set_beat(2, 2, 10, 7, 2);  set_beat(3, 3, 10, 7, 15);
    compute_model();
    start_run(); send_beats(0, N, 0); finish_run();
    n_checks++;
    if (pass !== 1'b1 || chk_cnt !== 8'(m_chk) || err_cnt !== 8'd0) begin
      n_fail++; $display("FAIL basic: pass=%0b chk=%0d err=%0d, required 1/%0d/0", pass, chk_cnt, err_cnt, m_chk);
    end
    n_checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || first_err_valid !== 1'b0) begin
      n_fail++; $display("FAIL basic_idle: busy=%0b in_ready=%0b fev=%0b, required 0/0/0", busy, in_ready, first_err_valid);
    end
  endtask

  task automatic test_error();
    set_beat(0, 0, 10, 7, 17); set_beat(1, 1, 10, 7, 4);
    set_beat(2, 2, 10, 7, 2);  set_beat(3, 3, 10, 7, 15);
    compute_model();
    start_run(); send_beats(0, N, 1); finish_run();
    n_checks++;
    if (err_cnt !== 8'(m_err) || pass !== 1'b0 || chk_cnt !== 8'(m_chk)) begin
      n_fail++; $display("FAIL error_counts: err=%0d pass=%0b chk=%0d, required %0d/0/%0d", err_cnt, pass, chk_cnt, m_err, m_chk);
    end
    n_checks++;
    if (first_err_valid !== 1'b1 || first_err_sel !== 2'(m_fsel) || first_err_exp !== 6'(m_fexp) || first_err_got !== 6'(m_fgot)) begin
      n_fail++; $display("FAIL error_capture: v=%0b sel=%0d exp=%0d got=%0d, required 1/%0d/%0d/%0d",
                         first_err_valid, first_err_sel, first_err_exp, first_err_got, m_fsel, m_fexp, m_fgot);
    end
  endtask

  task automatic test_wrap();
    set_beat(0, 1, 3, 7, 60);   set_beat(1, 0, 31, 31, 62);
    set_beat(2, 2, 21, 14, 4);  set_beat(3, 3, 21, 10, 31);
    compute_model();
    start_run(); send_beats(0, N, 0); finish_run();
    n_checks++;
    if (pass !== 1'(m_pass) || err_cnt !== 8'(m_err) || chk_cnt !== 8'(m_chk)) begin
      n_fail++; $display("FAIL wrap_carry: pass=%0b err=%0d chk=%0d, required %0d/%0d/%0d", pass, err_cnt, chk_cnt, m_pass, m_err, m_chk);
    end
  endtask

  task automatic test_gaps();
    int bad;
    bad = 0;
    for (int i = 0; i < N; i++) set_beat(i, i, 5 + i, 9, ref_alu(i, 5 + i, 9));
    compute_model();
    start_run(); send_beats(0, N, 3);
    // Extra beats after the last accept must all be refused.
    in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      sel = 2'($urandom_range(3, 0)); a = 5'($urandom); b = 5'($urandom); res = 6'($urandom);
      if (in_ready !== 1'b0) bad++;
      @(negedge clk);
    end
    finish_run();
    n_checks++;
    if (bad != 0) begin
      n_fail++; $display("FAIL extra_beats: in_ready high %0d times after last accept, required 0", bad);
    end
    n_checks++;
    if (chk_cnt !== 8'(m_chk) || pass !== 1'(m_pass)) begin
      n_fail++; $display("FAIL gaps_count: chk=%0d pass=%0b, required %0d/%0d", chk_cnt, pass, m_chk, m_pass);
    end
  endtask

  task automatic test_restart();
    set_beat(0, 0, 1, 2, 9); set_beat(1, 3, 4, 1, 0);
    start_run(); send_beats(0, 2, 0);
    for (int i = 0; i < N; i++) set_beat(i, 3 - i, 30 - i, 2 * i, ref_alu(3 - i, 30 - i, 2 * i));
    compute_model();
    start_run(); send_beats(0, N, 1); finish_run();
    n_checks++;
    if (chk_cnt !== 8'(m_chk) || err_cnt !== 8'd0 || pass !== 1'b1 || first_err_valid !== 1'b0) begin
      n_fail++; $display("FAIL restart: chk=%0d err=%0d pass=%0b fev=%0b, required %0d/0/1/0",
                         chk_cnt, err_cnt, pass, first_err_valid, m_chk);
    end
  endtask

  task automatic test_rst_mid();
    set_beat(0, 0, 1, 1, 7); set_beat(1, 1, 8, 2, 1);
    start_run(); send_beats(0, 2, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({busy, done, pass, in_ready, first_err_valid, err_cnt, chk_cnt, first_err_sel, first_err_exp, first_err_got} !== 35'b0) begin
      n_fail++; $display("FAIL rst_mid: busy=%0b done=%0b err=%0d chk=%0d fev=%0b fe=%0d/%0d/%0d, required all 0",
                         busy, done, err_cnt, chk_cnt, first_err_valid, first_err_sel, first_err_exp, first_err_got);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_stop_on_err();
    set_beat(0, 0, 2, 2, 4);  set_beat(1, 2, 12, 6, 5);
    set_beat(2, 3, 12, 6, 14); set_beat(3, 1, 12, 6, 6);
    compute_model();
    start_run(); send_beats(0, N, 0); finish_run();
    n_checks++;
    if (done !== 1'b1 || pass !== 1'b0 || chk_cnt !== 8'(m_chk) || err_cnt !== 8'(m_err) || in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stop_on_err: done=%0b pass=%0b chk=%0d err=%0d in_ready=%0b, required 1/0/%0d/%0d/0",
                         done, pass, chk_cnt, err_cnt, in_ready, m_chk, m_err);
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        int s, x, y, rv;
        s = $urandom_range(3, 0); x = $urandom_range(31, 0); y = $urandom_range(31, 0);
        rv = ($urandom_range(3, 0) == 0) ? $urandom_range(63, 0) : ref_alu(s, x, y);
        set_beat(i, s, x, y, rv);
      end
      compute_model();
      start_run(); send_beats(0, N, 2); finish_run();
      n_checks++;
      if (chk_cnt !== 8'(m_chk) || err_cnt !== 8'(m_err) || pass !== 1'(m_pass) || first_err_valid !== 1'(m_fv)) begin
        n_fail++; $display("FAIL random_run %0d counts: chk=%0d err=%0d pass=%0b fev=%0b, required %0d/%0d/%0d/%0d",
                           r, chk_cnt, err_cnt, pass, first_err_valid, m_chk, m_err, m_pass, m_fv);
      end
      n_checks++;
      if (first_err_sel !== 2'(m_fsel) || first_err_exp !== 6'(m_fexp) || first_err_got !== 6'(m_fgot)) begin
        n_fail++; $display("FAIL random_run %0d capture: sel=%0d exp=%0d got=%0d, required %0d/%0d/%0d",
                           r, first_err_sel, first_err_exp, first_err_got, m_fsel, m_fexp, m_fgot);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_error();
    test_wrap();
    test_gaps();
    test_restart();
    test_rst_mid();
    test_stop_on_err();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded 500000 time units");
    $fatal(1, "global timeout");
  end

endmodule
